// File: rtl/display_pkg.sv
// Shared types and constant tables for the seven-segment scan controller.
// Provides the scan FSM state type, blank pattern, hex segment and anode tables.
package display_pkg;

  typedef enum logic [1:0] {
    GAP = 2'd0,
    ON  = 2'd1,
    OFF = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; element N is hex digit N.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  // Active-low one-hot anode select; element N drives digit N.
  localparam logic [3:0][3:0] ANODE_SEL = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

endpackage

// File: rtl/display_scan_ctrl_hex7seg.sv
// Combinational hex to seven-segment decoder.
// Ports: hex_i (4-bit value) -> seg_no (active-low {g,f,e,d,c,b,a}).
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_no
);

  assign seg_no = SEG_TABLE[hex_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-slot multiplexed seven-segment scanner with gap, dimming and blink.
// Ports: clk_i, rst_ni (sync, active-low), digitN_i/digitN_en_i (N=0..3),
//   brightness_i, blink_i, blink_tick_i -> anode_no, cathode_no, frame_o.
// Option: DISPLAY_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 1024,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  input  logic [1:0] brightness_i,
  input  logic       blink_i,
  input  logic       blink_tick_i,
  output logic [3:0] anode_no,
  output logic [6:0] cathode_no,
  output logic       frame_o
);

  localparam int Q  = (REFRESH_DIV - GAP_CYCLES) / 4;
  localparam int CW = $clog2(REFRESH_DIV) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t GAP_LAST = cnt_t'(GAP_CYCLES - 1);
  localparam cnt_t Q_C      = cnt_t'(Q);
  localparam cnt_t WIN_C    = cnt_t'(4 * Q);
  localparam cnt_t ONE_C    = cnt_t'(1);

  scan_state_t state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [1:0]  slot_q, slot_d;
  logic [3:0]  val_q, val_d;
  logic        show_q, show_d;
  logic [1:0]  bright_q, bright_d;
  logic        phase_q, phase_d;
  logic [3:0]  anode_q, anode_d;
  logic [6:0]  cathode_q, cathode_d;
  logic        frame_q, frame_d;

  logic [3:0][3:0] val_in;
  logic [3:0]      en_in;
  logic [3:0]      show_in;
  cnt_t            on_len;
  cnt_t            off_len;
  logic [6:0]      seg;
  logic            suppress;

  assign val_in = {digit3_i, digit2_i, digit1_i, digit0_i};
  assign en_in  = {digit3_en_i, digit2_en_i,
                   digit1_en_i, digit0_en_i};

`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
  // A zero is leading when every slot above is disabled or
  // itself a leading zero; slot 0 always shows.
  logic [3:0] zsup;

  assign zsup[3] = (digit3_i == 4'd0);
  assign zsup[2] = (digit2_i == 4'd0)
                 && (!digit3_en_i || zsup[3]);
  assign zsup[1] = (digit1_i == 4'd0)
                 && (!digit3_en_i || zsup[3])
                 && (!digit2_en_i || zsup[2]);
  assign zsup[0] = 1'b0;
  assign show_in = en_in & ~zsup;
`else
  assign show_in = en_in;
`endif

  assign on_len  = Q_C * cnt_t'(bright_q) + Q_C;
  assign off_len = WIN_C - on_len;

  hex7seg u_hex7seg (
    .hex_i  (val_d),
    .seg_no (seg)
  );

  // Next-state: slot sequencing and per-slot latching.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + ONE_C;
    slot_d   = slot_q;
    val_d    = val_q;
    show_d   = show_q;
    bright_d = bright_q;
    frame_d  = 1'b0;
    unique case (state_q)
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d  = ON;
          cnt_d    = '0;
          val_d    = val_in[slot_q];
          show_d   = show_in[slot_q];
          bright_d = brightness_i;
        end
      end
      ON: begin
        if (cnt_q == on_len - ONE_C) begin
          cnt_d = '0;
          if (off_len == '0) begin
            state_d = GAP;
            slot_d  = slot_q + 2'd1;
            frame_d = (slot_q == 2'd3);
          end else begin
            state_d = OFF;
          end
        end
      end
      OFF: begin
        if (cnt_q == off_len - ONE_C) begin
          state_d = GAP;
          cnt_d   = '0;
          slot_d  = slot_q + 2'd1;
          frame_d = (slot_q == 2'd3);
        end
      end
      default: begin
        state_d = GAP;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line
  // up with the state register.
  always_comb begin
    phase_d   = phase_q ^ blink_tick_i;
    suppress  = !show_d || (blink_i && phase_d);
    anode_d   = ANODE_OFF;
    cathode_d = SEG_BLANK;
    if (state_d == ON && !suppress) begin
      anode_d   = ANODE_SEL[slot_d];
      cathode_d = seg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= GAP;
      cnt_q     <= '0;
      slot_q    <= 2'd0;
      val_q     <= 4'd0;
      show_q    <= 1'b0;
      bright_q  <= 2'd0;
      phase_q   <= 1'b0;
      anode_q   <= ANODE_OFF;
      cathode_q <= SEG_BLANK;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      val_q     <= val_d;
      show_q    <= show_d;
      bright_q  <= bright_d;
      phase_q   <= phase_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      frame_q   <= frame_d;
    end
  end

  assign anode_no   = anode_q;
  assign cathode_no = cathode_q;
  assign frame_o    = frame_q;

endmodule
